// File: rtl/regfile_operand_stage.sv
// Register file with write-back port and a one-entry operand register feeding the ALU.
// Source reads bypass a same-cycle write, so a captured instruction sees fresh data.
module regfile_operand_stage #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] AD1,
  input  logic [ADDRESS_WIDTH-1:0] AD2,
  input  logic [DATA_WIDTH-1:0]    ImmOp,
  input  logic                     ALUsrc,
  input  logic [4:0]               ALUctrl_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  input  logic                     WE3,
  input  logic [ADDRESS_WIDTH-1:0] AD3,
  input  logic [DATA_WIDTH-1:0]    WD3,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUop1,
  output logic [DATA_WIDTH-1:0]    ALUop2,
  output logic [4:0]               ALUctrl,
  output logic [DATA_WIDTH-1:0]    RD2_q,
  output logic [DATA_WIDTH-1:0]    a0
);

  localparam int unsigned NUM_REGS = 1 << ADDRESS_WIDTH;
  localparam int unsigned A0_INDEX = 10;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd1_c;
  logic [DATA_WIDTH-1:0] rd2_c;
  logic [DATA_WIDTH-1:0] op2_c;
  logic                  capture_c;

  // Register array: cleared by reset, x0 never written so it stays zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[ADDRESS_WIDTH'(i)] <= '0;
      end
    end else if (WE3 && (AD3 != '0)) begin
      regs[AD3] <= WD3;
    end
  end

  // Source reads with write bypass; index 0 forced to zero
  always_comb begin
    rd1_c = '0;
    rd2_c = '0;
    if (AD1 != '0) begin
      rd1_c = (WE3 && (AD3 == AD1)) ? WD3 : regs[AD1];
    end
    if (AD2 != '0) begin
      rd2_c = (WE3 && (AD3 == AD2)) ? WD3 : regs[AD2];
    end
  end

  assign op2_c     = ALUsrc ? ImmOp : rd2_c;
  assign in_ready  = !out_valid || out_ready;
  assign capture_c = in_valid && in_ready && !flush;
  assign a0        = regs[ADDRESS_WIDTH'(A0_INDEX)];

  // Operand register: load on capture, drop on consume or flush, hold while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      ALUop1    <= '0;
      ALUop2    <= '0;
      ALUctrl   <= '0;
      RD2_q     <= '0;
    end else if (capture_c) begin
      out_valid <= 1'b1;
      ALUop1    <= rd1_c;
      ALUop2    <= op2_c;
      ALUctrl   <= ALUctrl_in;
      RD2_q     <= rd2_c;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_operand_stage.sv
// Bench for regfile_operand_stage: directed scenarios followed by random traffic,
// all compared against a behavioural model of the register file and operand slot.
module tb_regfile_operand_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] AD1, AD2, AD3;
  logic [DW-1:0] ImmOp, WD3;
  logic          ALUsrc, in_valid, in_ready, flush, WE3, out_valid, out_ready;
  logic [4:0]    ALUctrl_in, ALUctrl;
  logic [DW-1:0] ALUop1, ALUop2, RD2_q, a0;

  always #5 clk = ~clk;

  regfile_operand_stage #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .AD1(AD1), .AD2(AD2), .ImmOp(ImmOp), .ALUsrc(ALUsrc),
    .ALUctrl_in(ALUctrl_in), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .WE3(WE3), .AD3(AD3), .WD3(WD3), .out_valid(out_valid), .out_ready(out_ready),
    .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrl(ALUctrl), .RD2_q(RD2_q), .a0(a0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [DW-1:0] m_regs [NR];
  logic          m_valid;
  logic [DW-1:0] m_op1, m_op2, m_rd2;
  logic [4:0]    m_ctl;
  bit            m_known = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural register read as seen by an instruction in the current cycle
  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] ad);
    if (ad == '0) return '0;
    if (WE3 && (AD3 == ad)) return WD3;
    return m_regs[ad];
  endfunction

  // One clock: check combinational outputs, advance model, check registered outputs
  task automatic tick();
    logic          cap, nv, was_rst;
    logic [DW-1:0] r1, r2;
    #1;
    if (m_known) begin
      chk("in_ready", DW'(in_ready), DW'(!m_valid || out_ready));
      chk("a0_pre", a0, m_regs[10]);
    end
    was_rst = rst;
    cap = !rst && in_valid && (!m_valid || out_ready) && !flush;
    nv  = cap || (m_valid && !out_ready && !flush);
    r1  = m_read(AD1);
    r2  = m_read(AD2);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_valid = 1'b0; m_op1 = '0; m_op2 = '0; m_rd2 = '0; m_ctl = '0;
      m_known = 1'b1;
    end else begin
      if (cap) begin
        m_op1 = r1;
        m_op2 = ALUsrc ? ImmOp : r2;
        m_rd2 = r2;
        m_ctl = ALUctrl_in;
      end
      m_valid = nv;
      if (WE3 && (AD3 != '0)) m_regs[AD3] = WD3;
    end
    #1;
    if (m_known) begin
      chk("out_valid", DW'(out_valid), DW'(m_valid));
      chk("a0", a0, m_regs[10]);
      if (m_valid || was_rst) begin
        chk("ALUop1", ALUop1, m_op1);
        chk("ALUop2", ALUop2, m_op2);
        chk("ALUctrl", DW'(ALUctrl), DW'(m_ctl));
        chk("RD2_q", RD2_q, m_rd2);
      end
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; AD1 = '0; AD2 = '0; AD3 = '0; ImmOp = '0; WD3 = '0;
    ALUsrc = 1'b0; in_valid = 1'b0; flush = 1'b0; WE3 = 1'b0;
    out_ready = 1'b1; ALUctrl_in = '0;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_valid = 1'b0; m_op1 = '0; m_op2 = '0; m_rd2 = '0; m_ctl = '0;
    idle_inputs();

    // Reset then read
    rst = 1'b1;
    tick();
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_a0", a0, 32'h0);
    rst = 1'b0; in_valid = 1'b1; AD1 = 5'd10; AD2 = 5'd5;
    tick();
    chk("rd_after_rst_valid", DW'(out_valid), DW'(1));
    chk("rd_after_rst_op1", ALUop1, 32'h0);
    chk("rd_after_rst_op2", ALUop2, 32'h0);

    // Write x10, attempt write to x0
    in_valid = 1'b0; WE3 = 1'b1; AD3 = 5'd10; WD3 = 32'h0000_00FF;
    tick();
    AD3 = 5'd0; WD3 = 32'h0000_1234;
    tick();
    WE3 = 1'b0; in_valid = 1'b1; AD1 = 5'd10; AD2 = 5'd0; ALUsrc = 1'b0;
    tick();
    chk("x0_a0", a0, 32'h0000_00FF);
    chk("x0_op1", ALUop1, 32'h0000_00FF);
    chk("x0_op2", ALUop2, 32'h0);

    // Same-cycle write bypass
    WE3 = 1'b1; AD3 = 5'd3; WD3 = 32'hDEAD_BEEF;
    AD1 = 5'd3; AD2 = 5'd10; ALUsrc = 1'b1; ImmOp = 32'hFFFF_FFFC;
    tick();
    chk("byp_op1", ALUop1, 32'hDEAD_BEEF);
    chk("byp_op2", ALUop2, 32'hFFFF_FFFC);
    chk("byp_rd2", RD2_q, 32'h0000_00FF);

    // Stall: capture ctrl=1 reading x4, then hold while writing x4
    WE3 = 1'b0; AD1 = 5'd4; AD2 = 5'd3; ALUsrc = 1'b0; ALUctrl_in = 5'd1;
    tick();
    out_ready = 1'b0; AD1 = 5'd3; ALUctrl_in = 5'd2;
    WE3 = 1'b1; AD3 = 5'd4; WD3 = 32'd7;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_in_ready", DW'(in_ready), DW'(0));
      chk("stall_op1", ALUop1, 32'h0);
      chk("stall_op2", ALUop2, 32'hDEAD_BEEF);
      chk("stall_ctl", DW'(ALUctrl), DW'(1));
    end
    out_ready = 1'b1; in_valid = 1'b0; WE3 = 1'b0;
    tick();
    chk("release_valid", DW'(out_valid), DW'(0));

    // Back-to-back throughput
    in_valid = 1'b1; AD1 = 5'd4;
    for (int k = 0; k < 4; k++) begin
      ALUctrl_in = 5'(k);
      tick();
      chk("b2b_valid", DW'(out_valid), DW'(1));
      chk("b2b_ctl", DW'(ALUctrl), DW'(k));
      chk("b2b_op1", ALUop1, 32'd7);
    end

    // Flush drops held entry and same-cycle input
    flush = 1'b1;
    tick();
    chk("flush_valid", DW'(out_valid), DW'(0));
    flush = 1'b0;
    tick();

    // Reset priority over stall and write
    rst = 1'b1; out_ready = 1'b0; WE3 = 1'b1; AD3 = 5'd5; WD3 = 32'h99;
    tick();
    chk("rstp_valid", DW'(out_valid), DW'(0));
    rst = 1'b0; WE3 = 1'b0; out_ready = 1'b1; AD1 = 5'd5; AD2 = 5'd10;
    tick();
    chk("rstp_x5", ALUop1, 32'h0);
    chk("rstp_a0", a0, 32'h0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(63) == 0);
      flush      = ($urandom_range(7) == 0);
      in_valid   = 1'($urandom_range(1));
      out_ready  = ($urandom_range(3) != 0);
      AD1        = ($urandom_range(1) == 1) ? AW'($urandom_range(7)) : AW'($urandom);
      AD2        = ($urandom_range(1) == 1) ? AW'($urandom_range(7)) : AW'($urandom);
      AD3        = ($urandom_range(1) == 1) ? AW'($urandom_range(11)) : AW'($urandom);
      ImmOp      = DW'($urandom);
      WD3        = DW'($urandom);
      ALUsrc     = 1'($urandom_range(1));
      WE3        = 1'($urandom_range(1));
      ALUctrl_in = 5'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_operand_stage.md
Name: regfile_operand_stage

Overview:
- Register file plus one-entry operand pipeline register directly upstream of the ALU.
- Reads two source registers and selects register or immediate for operand 2.
- Latches ALUop1, ALUop2 and ALUctrl behind a valid/ready handshake, so the ALU sees stable operands for a full cycle.
- Also owns the write-back port and exposes a0 (x10) for the testbench and top-level display.

Parameters:
- DATA_WIDTH, 32, width of registers, operands and immediates.
- ADDRESS_WIDTH, 5, register index width; 2**ADDRESS_WIDTH registers.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- AD1  input  ADDRESS_WIDTH  source register 1 index.
- AD2  input  ADDRESS_WIDTH  source register 2 index.
- ImmOp  input  DATA_WIDTH  sign-extended immediate.
- ALUsrc  input  1  1 selects ImmOp as operand 2; 0 selects register AD2.
- ALUctrl_in  input  5  ALU operation code, passed through unchanged.
- in_valid  input  1  upstream presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- flush  input  1  discard the held entry.
- WE3  input  1  write enable.
- AD3  input  ADDRESS_WIDTH  write register index.
- WD3  input  DATA_WIDTH  write data.
- out_valid  output  1  operands valid toward the ALU.
- out_ready  input  1  ALU/downstream consumes this cycle.
- ALUop1  output  DATA_WIDTH  registered operand 1.
- ALUop2  output  DATA_WIDTH  registered operand 2.
- ALUctrl  output  5  registered operation code.
- RD2_q  output  DATA_WIDTH  registered register-2 value (store data), independent of ALUsrc.
- a0  output  DATA_WIDTH  combinational view of register x10.

Behaviour:
- Clock and reset:
  - One clock (clk).
  - Reset (rst) is synchronous and active-high.
  - rst is sampled on the clk rising edge and has priority over every other input.
- Reset state:
  - All registers are 0.
  - out_valid=0; ALUop1, ALUop2, RD2_q = 0; ALUctrl=0.
  - a0 is therefore 0 after reset.
- Register x0:
  - Reads always return 0.
  - A write with AD3=0 is discarded.
- Write:
  - On a rising edge with WE3=1, rst=0 and AD3!=0, reg[AD3] <= WD3.
- Read with write bypass (combinational):
  - RDn = (WE3 && AD3==ADn && AD3!=0) ? WD3 : reg[ADn].
  - An instruction captured in the same cycle as a write to its source register sees the new value.
- Operand 2:
  - op2 = ALUsrc ? ImmOp : RD2.
  - op1 = RD1.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Capture happens when in_valid && in_ready && !flush.
  - On capture, ALUop1/ALUop2/ALUctrl/RD2_q load the next edge and out_valid <= 1.
  - If there is no capture and out_ready=1, out_valid <= 0.
- Stall:
  - While out_valid && !out_ready, all registered outputs hold bit-stable.
  - Register writes during a stall do not alter held operands.
- Flush:
  - flush=1 forces out_valid <= 0 next edge, and the same-cycle input is dropped.
  - Operand registers may keep stale data; only out_valid is checked.
  - Register-file writes still occur during flush.
- Simultaneous events:
  - Consume plus capture in the same cycle gives back-to-back throughput: out_valid stays 1 with the new data.
  - Latency is 1 cycle from capture to out_valid.
- Reset mid-operation:
  - rst=1 with out_valid=1 clears out_valid and all registers next edge, regardless of out_ready, flush or WE3.
- Arithmetic:
  - No arithmetic is performed; widths pass through unchanged.
  - ALUctrl values above 3 are passed through untouched; the ALU defaults them to 0.

Test Plan:
- Reset then read: rst=1 one cycle, then AD1=10, AD2=5 captured -> ALUop1=0, ALUop2=0, a0=0, out_valid=1 next cycle.
- Write and x0 protection:
  - Write WD3=0x0000_00FF to AD3=10; write 0x1234 to AD3=0.
  - Then capture AD1=10, AD2=0, ALUsrc=0 -> a0=0xFF, ALUop1=0xFF, ALUop2=0.
- Bypass: same cycle WE3=1, AD3=3, WD3=0xDEAD_BEEF and capture AD1=3, ALUsrc=1, ImmOp=0xFFFF_FFFC -> ALUop1=0xDEADBEEF, ALUop2=0xFFFFFFFC, RD2_q=reg[AD2].
- Stall:
  - Capture ALUctrl_in=1, then hold out_ready=0 for 3 cycles while writing reg[AD1]=7 -> outputs unchanged, in_ready=0.
  - Release out_ready -> out_valid drops one cycle later.
- Back-to-back: in_valid=1 and out_ready=1 for 4 consecutive instructions (ALUctrl 0,1,2,3) -> out_valid continuous, ALUctrl sequence 0,1,2,3 on consecutive cycles.
- Flush and reset priority:
  - flush=1 with in_valid=1 -> out_valid=0 next cycle.
  - rst=1 while out_valid=1, out_ready=0, WE3=1 to x5 -> out_valid=0, reg[5]=0.
